ssram_stream_reader: RTL

Read-side engine for the 128 x 32 semi-dual-port SSRAM buffer. On a start command it walks a block of consecutive addresses through the RAM's registered read port (one-cycle read latency) and streams the words out on a valid/ready interface. Full throughput is one word per cycle; backpressure is absorbed by a 2-entry output buffer. It sits between the RAM's read port and any downstream consumer, for example a UART transmitter, DMA master or bus responder.

---
 rtl/ssram_stream_reader.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ssram_stream_reader.sv
// ssram_stream_reader
//
// Read-side engine for a 128 x 32 semi-dual-port SSRAM with a registered
// (one-cycle latency) read port. A start command walks a block of
// consecutive addresses (wrapping modulo 128) and streams the returned words
// out on a valid/ready interface at up to one word per cycle. A 2-entry
// output FIFO absorbs backpressure. Occupancy is the buffered words plus the
// read in flight, and it never exceeds 2.
//
// Ports:
//   clock        single clock for this block and the RAM read port
//   reset        synchronous, active-high; clears all state, aborts a transfer
//   start        transfer request, sampled only while idle
//   startAddress first RAM address to read
//   wordCount    number of words to transfer (0 means 128)
//   addressB     read address to the RAM
//   dataOutB     RAM read data, valid one cycle after addressB
//   dataOut      stream data (0 while dataValid is low)
//   dataValid    dataOut holds a word
//   dataReady    consumer accepts the word this cycle
//   busy         a transfer is in progress
//   done         one-cycle pulse after the last word has been accepted
//   checksum     modulo-2^32 sum of accepted words
//                (only when READER_CHECKSUM_EN is defined)
//
// Build option: define READER_CHECKSUM_EN to add the checksum port and its
// accumulator.
module ssram_stream_reader (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  startAddress,
  input  logic [6:0]  wordCount,
  output logic [6:0]  addressB,
  input  logic [31:0] dataOutB,
  output logic [31:0] dataOut,
  output logic        dataValid,
  input  logic        dataReady,
  output logic        busy,
  output logic        done
`ifdef READER_CHECKSUM_EN
  ,
  output logic [31:0] checksum
`endif
);

  localparam int DATA_W = 32;
  localparam int ADDR_W = 7;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   last_q;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic                inflight_q;
  logic [1:0]          cnt_q, cnt_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   fifo0_q, fifo1_q;

  logic                accept;
  logic                issue;
  logic [1:0]          occ;

  assign dataValid = (cnt_q != 2'd0);
  assign accept    = dataValid && dataReady;
  assign occ       = cnt_q + {1'b0, inflight_q};
  // The read returning this cycle lands in the FIFO; an accepted word leaves.
  assign cnt_d     = cnt_q + {1'b0, inflight_q} - {1'b0, accept};

  // The address is live only in an issuing cycle; otherwise the last issued
  // address is held so the RAM port does not toggle needlessly.
  assign addressB  = issue ? ptr_q : last_q;
  assign dataOut   = dataValid ? fifo0_q : '0;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    issue   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          ptr_d   = startAddress;
          rem_d   = (wordCount == 7'd0) ? 8'd128 : {1'b0, wordCount};
        end
      end
      READ: begin
        // A word leaving this cycle frees a slot, so a full buffer may still
        // issue; this is what keeps streaming bubble-free.
        if ((rem_q != '0) && ((occ < 2'd2) || accept)) begin
          issue = 1'b1;
          ptr_d = ptr_q + 7'd1;
          rem_d = rem_q - 8'd1;
        end
        if (rem_d == '0) state_d = DRAIN;
      end
      DRAIN: begin
        // Finish on the edge that empties the pipeline so busy drops together
        // with the done pulse and a new start can be taken right away.
        if (cnt_d == 2'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      last_q     <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= 2'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      last_q     <= addressB;
      inflight_q <= issue;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
    end
  end

  // FIFO storage: fifo0_q is the head. Occupancy never exceeds 2, so a
  // returning read always finds a free slot.
  always_ff @(posedge clock) begin
    case ({inflight_q, accept})
      2'b10: begin
        if (cnt_q == 2'd0) fifo0_q <= dataOutB;
        else               fifo1_q <= dataOutB;
      end
      2'b11:   fifo0_q <= dataOutB;
      2'b01:   fifo0_q <= fifo1_q;
      default: ;
    endcase
  end

`ifdef READER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sum_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= sum_q + dataOut;
    end
  end

  assign checksum = sum_q;
`endif

endmodule
